prng_arbiter: RTL
=================

# prng_arbiter

Controller that owns the shared PRNG block. It seeds the PRNG through its synchronous set input and re-seeds it on request or after a fixed number of draws. It shares the PRNG's free-running output among NREQ requesters through a round-robin req/gnt handshake. It sits between the PRNG instance and all consumers of random words; no consumer connects to the PRNG directly.

## Interface
- WIDTH, 8, width of PRNG output word
- NREQ, 4, number of requesters (2..8)
- SETTLE, 2, cycles to wait after the seed pulse before the first draw (>=1)
- RESEED_PERIOD, 64, grants between automatic reseeds; 0 disables auto-reseed

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- prng_set  out  1  drives PRNG set_syn; high for exactly one cycle per seed
- prng_q  in  WIDTH  PRNG current output; advances every clk
- req  in  NREQ  request lines, level; bit i = requester i
- reseed  in  1  reseed request, sampled only in IDLE
- gnt  out  NREQ  one-hot grant, one-cycle pulse, registered
- rnd_out  out  WIDTH  random word for the granted requester; valid while rnd_valid=1
- rnd_valid  out  1  high in the same cycle as any gnt bit
- busy  out  1  high while seeding/settling (states INIT, SEED, SETTLE)
- draw_cnt  out  clog2(RESEED_PERIOD+1)  grants since last seed

## Operation
- FSM states: INIT, SEED, SETTLE, IDLE. Outputs prng_set and busy are decoded from the registered state.
- Reset (rst_n low, asynchronous) forces:
  - state=INIT, prng_set=0, gnt=0, rnd_valid=0, rnd_out=0, busy=1
  - round-robin pointer ptr=0, draw_cnt=0, settle counter=0
- INIT -> SEED on the first edge after rst_n rises.
- SEED: prng_set=1 for one cycle -> SETTLE. draw_cnt cleared.
- SETTLE: counts SETTLE cycles, then -> IDLE. busy=0 in IDLE only.
- IDLE, at each edge:
  - If reseed=1: go to SEED. No grant is issued that edge. reseed wins over req.
  - Else compute the eligible set as req with the currently asserted gnt bit masked out.
    - The requester granted in this cycle cannot win again at the same edge.
    - A requester holding req continuously gets at most one grant every 2 cycles if it is alone, or one per round if others compete.
  - If the eligible set is non-empty:
    - Winner = first eligible index searching ptr, ptr+1, ... mod NREQ.
    - Register gnt=onehot(winner), rnd_valid=1, rnd_out=prng_q.
    - Set ptr=(winner+1) mod NREQ and draw_cnt+=1.
  - Otherwise gnt=0 and rnd_valid=0.
- Auto-reseed: if RESEED_PERIOD!=0 and a grant brings draw_cnt to RESEED_PERIOD, the same edge moves the FSM to SEED. That grant is still issued normally.
- Outside IDLE: gnt=0, rnd_valid=0. req and reseed are ignored and not latched. Requesters keep req asserted and are served after returning to IDLE.
- rnd_out holds its last value when rnd_valid=0.
- The requester protocol is the consumer's contract: drop req in the cycle gnt[i] is seen, unless it wants another word.

## Timing
- Edge numbering after rst_n rises: edge 1 -> SEED (prng_set high during cycle 1).
- Edge 2 -> SETTLE. Edge 2+SETTLE -> IDLE, busy=0.
- The earliest grant is registered at edge 3+SETTLE (with default SETTLE=2: first gnt at cycle 5).
- Grant latency: req seen at edge n -> gnt/rnd_valid/rnd_out visible in cycle n (registered at edge n), held one cycle.
- rnd_out equals the prng_q value present just before the granting edge.
- Reseed cost: 1 (SEED) + SETTLE cycles with no grants.
- Maximum throughput: one grant per cycle when at least two requesters are active.
- Asynchronous reset mid-grant: gnt, rnd_valid and prng_set clear immediately, without waiting for clk.

## Test plan
- Reset/seed: hold rst_n=0 -> busy=1, all other outputs 0. Release -> prng_set=1 only in cycle 1; busy=0 from cycle 4 (SETTLE=2); no gnt before cycle 5.
- Single requester: req=4'b0100 held -> gnt=4'b0100 in alternate cycles. Each rnd_out matches the prng_q sampled at that edge. draw_cnt increments per grant.
- Full contention: req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001 in consecutive cycles. ptr wraps 3->0.
- Auto-reseed: RESEED_PERIOD=4, req=4'b0011 held -> 4 grants, then prng_set pulse, then 1+SETTLE grant-free cycles. draw_cnt=0 after SEED; grants resume with ptr preserved.
- Reseed collisions:
  - reseed=1 and req=4'b0001 at the same IDLE edge -> no gnt, prng_set next cycle.
  - reseed pulsed during SETTLE -> ignored; IDLE is reached on schedule.
- Reset mid-operation: drop rst_n while gnt=4'b0010 -> gnt=0, rnd_valid=0 immediately. After release, the full seed sequence repeats and the first winner is requester 0.

Source files
------------

// File: rtl/prng_arbiter.sv
// Shares one free-running PRNG among NREQ requesters with round-robin, one-cycle grants.
// Latency: req sampled at edge n -> gnt/rnd_valid/rnd_out registered at edge n; seeding costs 1+SETTLE cycles.
// Backpressure: none; requesters hold req until they see gnt, and req/reseed are ignored while busy.
module prng_arbiter #(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int SETTLE        = 2,
  parameter int RESEED_PERIOD = 64,
  localparam int CW = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             prng_set,
  input  logic [WIDTH-1:0] prng_q,
  input  logic [NREQ-1:0]  req,
  input  logic             reseed,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd_out,
  output logic             rnd_valid,
  output logic             busy,
  output logic [CW-1:0]    draw_cnt
);

  localparam int  PW    = $clog2(NREQ);
  localparam int  SCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam bit  AUTO  = (RESEED_PERIOD > 0);
  localparam int  RP_M1 = (RESEED_PERIOD > 0) ? RESEED_PERIOD - 1 : 0;

  typedef enum logic [1:0] {
    S_INIT,
    S_SEED,
    S_SETTLE,
    S_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic [WIDTH-1:0] rnd_out_q, rnd_out_d;

  logic [NREQ-1:0]  elig;
  logic             win_vld;
  logic [PW-1:0]    win;

  // Round-robin search starting at ptr; the requester granted this cycle is masked
  // so a lone requester holding req is served at most every other cycle.
  always_comb begin
    elig    = req & ~gnt_q;
    win_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  // Next-state logic: seeding sequence, then grant issue and auto-reseed in IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_out_d   = rnd_out_q;
    case (state_q)
      S_INIT: begin
        state_d = S_SEED;
      end
      S_SEED: begin
        state_d  = S_SETTLE;
        cnt_d    = '0;
        settle_d = '0;
      end
      S_SETTLE: begin
        if (settle_q == SCW'(SETTLE - 1)) begin
          state_d  = S_IDLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (reseed) begin
          // Reseed wins over any pending request; no grant this edge.
          state_d = S_SEED;
        end else if (win_vld) begin
          gnt_d[win]  = 1'b1;
          rnd_valid_d = 1'b1;
          rnd_out_d   = prng_q;
          ptr_d       = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          cnt_d       = cnt_q + 1'b1;
          // The grant that reaches the period is still delivered; seeding follows.
          if (AUTO && (cnt_q == CW'(RP_M1))) begin
            state_d = S_SEED;
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and registered outputs; async reset clears grants at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_out_q   <= rnd_out_d;
    end
  end

  assign prng_set  = (state_q == S_SEED);
  assign busy      = (state_q != S_IDLE);
  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_out   = rnd_out_q;
  assign draw_cnt  = cnt_q;

endmodule
